seven_seg_scan_reader: RTL
==========================

# seven_seg_scan_reader

Observes a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and recovers the displayed digits as 4-bit codes. It is the reverse path of the segment decoder: it turns segment patterns back into values. It is used for loopback self-check of the display path and for board-level verification of the counter output. A multi-digit value is published only after it has been stable for a programmable number of complete scan frames.

## Interface
Parameters:
- NUM_DIGITS, 4: number of multiplexed digits / anode lines.
- MIN_DWELL, 4: consecutive identical cycles required before a digit sample is accepted (≥1).
- STABLE_FRAMES, 2: identical complete frames required before publishing (≥1).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seg  in  7  segment lines, active-low, bit 0 = segment a … bit 6 = segment g.
- an  in  NUM_DIGITS  anode selects, active-low; bit i selects digit i.
- digits  out  4*NUM_DIGITS  published codes; digit i occupies bits [4i+3:4i].
- digit_err  out  NUM_DIGITS  bit i set if the published digit i was an unrecognised pattern.
- valid  out  1  one-cycle pulse when digits/digit_err update.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Encoding:
  - 0x40 → 0, 0x79 → 1, 0x24 → 2, 0x30 → 3, 0x19 → 4, 0x12 → 5, 0x02 → 6, 0x78 → 7, 0x00 → 8, 0x10 → 9.
  - 0x7F (blank) → 4'hF, no error.
  - Any other pattern → 4'hE with the error flag set.
- Dwell:
  - A counter increments while both `an` and `seg` are unchanged from the previous cycle and saturates at MIN_DWELL.
  - Any change to either input clears the counter to 0.
  - A sample is accepted once, on the cycle the counter reaches MIN_DWELL-1, and only if `an` is exactly one-hot low.
- `an` all-high: idle; no capture and no error.
- `an` with more than one low bit, held for MIN_DWELL cycles: frame_err pulses, the frame buffer's seen mask clears, and the FSM returns to IDLE.
- Accepted sample for digit i: the code and error flag are written into the frame buffer slot i and seen[i] is set. A re-accept of the same digit overwrites the slot.
- FSM:
  - IDLE → COLLECT on the first accepted sample.
  - COLLECT → COMPARE when the seen mask is all ones.
  - COMPARE (1 cycle) → COLLECT with the seen mask cleared.
- COMPARE:
  - If the frame equals the previous complete frame (codes and error flags), match_cnt increments, saturating at STABLE_FRAMES-1. Otherwise match_cnt is 0 and the frame is stored as the previous frame.
  - If match_cnt reaches STABLE_FRAMES-1 and the frame differs from the currently published outputs, load digits and digit_err and pulse valid.
  - Re-stabilising on the already-published value produces no pulse.
  - With STABLE_FRAMES=1, every new complete frame that differs from the published value publishes.

## Timing
- Reset values: digits = all 4'hF, digit_err = 0, valid = 0, frame_err = 0. FSM goes to IDLE; counters, seen mask, previous frame and match_cnt are all cleared.
- Reset mid-frame discards all partial state immediately (asynchronous).
- Sample acceptance happens MIN_DWELL cycles after the last input change. seen[i] is visible on the following cycle.
- COMPARE occurs the cycle after the last seen bit sets. valid and the new digits are registered and visible on the cycle after COMPARE.
- frame_err is registered: it pulses the cycle after the MIN_DWELL-th cycle of a multi-low `an`.
- If a multi-low abort coincides with frame completion, the abort wins: no COMPARE, frame_err pulses.
- Counters never wrap: dwell saturates at MIN_DWELL, match_cnt saturates at STABLE_FRAMES-1.

## Structure
- Package `seven_seg_pkg`:
  - SEG_0…SEG_9 and SEG_BLANK pattern constants (7-bit, active-low).
  - CODE_BLANK = 4'hF, CODE_INVALID = 4'hE.
  - FSM state typedef {IDLE, COLLECT, COMPARE}.
- One sub-module `seven_seg_encoder`: combinational, seg → 4-bit code + invalid flag. Instantiated once, on the sampled `seg`.
- Top-level holds the dwell counter, frame buffer, previous-frame register, match counter, FSM and output registers.

## Test plan
- Reset, then scan "1234" (an = 1110, 1101, 1011, 0111 with patterns 0x79, 0x24, 0x30, 0x19), 8 cycles per digit, 2 frames → single valid pulse, digits = 16'h4321, digit_err = 0.
- Continue the identical scan for 5 more frames → no further valid pulses. Then change digit 0 to 0x40 for 2 frames → one valid, digits = 16'h4320.
- Digit 2 pattern 0x7F across 2 frames → digits[11:8] = 4'hF, digit_err[2] = 0. Pattern 0x55 → 4'hE, digit_err[2] = 1, valid pulses.
- Each digit held only MIN_DWELL-1 cycles → no acceptance, no valid ever. A 1-cycle seg glitch inside a digit's dwell → that dwell restarts; the frame still publishes correctly if the dwell is long enough.
- an = 1100 for 4 cycles mid-frame → frame_err pulses once; the partial frame is discarded; 2 clean frames afterwards publish normally.
- Assert rst during the second frame of a new value → outputs return to 4'hF/0 immediately; no valid until 2 clean frames after release.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scan reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seven_seg_pkg;

    // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CODE_INVALID = 4'hE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMPARE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_reader_encoder.sv
// Segment pattern to 4-bit code; unknown patterns map to CODE_INVALID with invalid set.
// Latency: combinational.
// Backpressure: none.
// Ports: seg (active-low pattern in), code (digit code out), invalid (unrecognised pattern).
module seven_seg_encoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       invalid
);

    always_comb begin
        code    = CODE_INVALID;
        invalid = 1'b1;
        case (seg)
            SEG_0:     begin code = 4'd0;       invalid = 1'b0; end
            SEG_1:     begin code = 4'd1;       invalid = 1'b0; end
            SEG_2:     begin code = 4'd2;       invalid = 1'b0; end
            SEG_3:     begin code = 4'd3;       invalid = 1'b0; end
            SEG_4:     begin code = 4'd4;       invalid = 1'b0; end
            SEG_5:     begin code = 4'd5;       invalid = 1'b0; end
            SEG_6:     begin code = 4'd6;       invalid = 1'b0; end
            SEG_7:     begin code = 4'd7;       invalid = 1'b0; end
            SEG_8:     begin code = 4'd8;       invalid = 1'b0; end
            SEG_9:     begin code = 4'd9;       invalid = 1'b0; end
            SEG_BLANK: begin code = CODE_BLANK; invalid = 1'b0; end
            default:   begin code = CODE_INVALID; invalid = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// Recovers digit codes from a multiplexed active-low 7-seg bus; publishes after STABLE_FRAMES identical frames.
// Latency: sample accepted MIN_DWELL cycles after the last input change; valid one cycle after COMPARE.
// Backpressure: none; observe-only, outputs are pulses with held digits.
// Ports: clk, rst (async high); seg/an observed bus; digits/digit_err published frame;
//        valid pulses on publish; frame_err pulses when a multi-low anode pattern aborts a frame.
module seven_seg_scan_reader
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int MIN_DWELL     = 4,
    parameter int STABLE_FRAMES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    valid,
    output logic                    frame_err
);

    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int MW = (STABLE_FRAMES > 1) ? $clog2(STABLE_FRAMES) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
    localparam logic [DW-1:0] DWELL_HIT = DW'(MIN_DWELL - 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES - 1);

    logic [NUM_DIGITS-1:0]   an_prev_q, an_prev_d;
    logic [6:0]              seg_prev_q, seg_prev_d;
    logic [DW-1:0]           dwell_q, dwell_d;
    logic [4*NUM_DIGITS-1:0] buf_code_q, buf_code_d;
    logic [NUM_DIGITS-1:0]   buf_err_q, buf_err_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic [4*NUM_DIGITS-1:0] prev_code_q, prev_code_d;
    logic [NUM_DIGITS-1:0]   prev_err_q, prev_err_d;
    logic                    prev_vld_q, prev_vld_d;
    logic [MW-1:0]           match_q, match_d;
    logic [4*NUM_DIGITS-1:0] pub_code_q, pub_code_d;
    logic [NUM_DIGITS-1:0]   pub_err_q, pub_err_d;
    logic                    valid_q, valid_d;
    logic                    ferr_q, ferr_d;
    scan_state_t             state_q, state_d;

    logic [NUM_DIGITS-1:0]   an_low;
    logic                    one_hot, multi_low, same_in, dwell_hit;
    logic                    accept, abort, same_frame;
    logic [3:0]              enc_code;
    logic                    enc_invalid;

    seven_seg_encoder u_enc (
        .seg     (seg),
        .code    (enc_code),
        .invalid (enc_invalid)
    );

    // Dwell qualification: the hit fires exactly once per stable stretch
    // because the counter moves past DWELL_HIT to DWELL_MAX and sticks there.
    always_comb begin
        an_low    = ~an;
        multi_low = (an_low & (an_low - NUM_DIGITS'(1))) != '0;
        one_hot   = (an_low != '0) && !multi_low;
        same_in   = (an == an_prev_q) && (seg == seg_prev_q);

        an_prev_d  = an;
        seg_prev_d = seg;
        if (!same_in) begin
            dwell_d = '0;
        end else if (dwell_q == DWELL_MAX) begin
            dwell_d = dwell_q;
        end else begin
            dwell_d = dwell_q + DW'(1);
        end
        dwell_hit = (dwell_d == DWELL_HIT);
        accept    = dwell_hit && one_hot;
        abort     = dwell_hit && multi_low;
    end

    always_comb begin
        state_d     = state_q;
        seen_d      = seen_q;
        buf_code_d  = buf_code_q;
        buf_err_d   = buf_err_q;
        prev_code_d = prev_code_q;
        prev_err_d  = prev_err_q;
        prev_vld_d  = prev_vld_q;
        match_d     = match_q;
        pub_code_d  = pub_code_q;
        pub_err_d   = pub_err_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        same_frame  = prev_vld_q && (buf_code_q == prev_code_q) && (buf_err_q == prev_err_q);

        if (abort) begin
            // Abort beats any pending comparison.
            ferr_d  = 1'b1;
            seen_d  = '0;
            state_d = IDLE;
        end else begin
            if (state_q == COMPARE) begin
                if (same_frame) begin
                    match_d = (match_q == MATCH_MAX) ? match_q : match_q + MW'(1);
                end else begin
                    match_d     = '0;
                    prev_code_d = buf_code_q;
                    prev_err_d  = buf_err_q;
                    prev_vld_d  = 1'b1;
                end
                if ((match_d == MATCH_MAX) &&
                    ((buf_code_q != pub_code_q) || (buf_err_q != pub_err_q))) begin
                    pub_code_d = buf_code_q;
                    pub_err_d  = buf_err_q;
                    valid_d    = 1'b1;
                end
                seen_d = '0;
            end

            // A sample landing in the COMPARE cycle starts the next frame;
            // the comparison above reads the pre-write buffer.
            if (accept) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (an_low[i]) begin
                        buf_code_d[4*i +: 4] = enc_code;
                        buf_err_d[i]         = enc_invalid;
                    end
                end
                seen_d = seen_d | an_low;
            end

            case (state_q)
                IDLE:    if (accept) state_d = (&seen_d) ? COMPARE : COLLECT;
                COLLECT: if (&seen_d) state_d = COMPARE;
                COMPARE: state_d = (&seen_d) ? COMPARE : COLLECT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_prev_q   <= '1;
            seg_prev_q  <= SEG_BLANK;
            dwell_q     <= '0;
            buf_code_q  <= '0;
            buf_err_q   <= '0;
            seen_q      <= '0;
            prev_code_q <= '0;
            prev_err_q  <= '0;
            prev_vld_q  <= 1'b0;
            match_q     <= '0;
            pub_code_q  <= '1;
            pub_err_q   <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            state_q     <= IDLE;
        end else begin
            an_prev_q   <= an_prev_d;
            seg_prev_q  <= seg_prev_d;
            dwell_q     <= dwell_d;
            buf_code_q  <= buf_code_d;
            buf_err_q   <= buf_err_d;
            seen_q      <= seen_d;
            prev_code_q <= prev_code_d;
            prev_err_q  <= prev_err_d;
            prev_vld_q  <= prev_vld_d;
            match_q     <= match_d;
            pub_code_q  <= pub_code_d;
            pub_err_q   <= pub_err_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            state_q     <= state_d;
        end
    end

    assign digits    = pub_code_q;
    assign digit_err = pub_err_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;

endmodule
